// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and constants for the traffic phase scheduler and its helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10
  } phase_e;

  localparam int DEF_NUM_APPROACH = 4;
  localparam int DEF_MIN_GREEN    = 1000;
  localparam int DEF_MAX_GREEN    = 3000;
  localparam int DEF_YELLOW_TIME  = 500;
  localparam int DEF_ALLRED_TIME  = 100;
  localparam int DEF_CWIDTH       = 16;

  localparam logic LAMP_ON  = 1'b1;
  localparam logic LAMP_OFF = 1'b0;

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/timebase inputs and lamp outputs of the phase scheduler.
interface traffic_phase_scheduler_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic          tick;
  logic [N-1:0]  req;
  logic [N-1:0]  green;
  logic [N-1:0]  yellow;
  logic [N-1:0]  red;
  logic [IW-1:0] active_idx;
  logic          phase_done;

  modport master (
    output tick, req,
    input  green, yellow, red, active_idx, phase_done
  );

  modport slave (
    input  tick, req,
    output green, yellow, red, active_idx, phase_done
  );
endinterface

// File: rtl/traffic_phase_scheduler_rr_picker.sv
// Combinational round-robin picker: first requester after i_last_idx, wrapping.
module traffic_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last_idx,
  output logic [$clog2(N)-1:0] o_grant,
  output logic                 o_valid
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] w_cand;

  // Scan farthest-first so the nearest requester after i_last_idx wins.
  always_comb begin
    o_grant = '0;
    w_cand  = '0;
    for (int i = N; i >= 1; i--) begin
      w_cand = IW'((int'(i_last_idx) + i) % N);
      if (i_req[w_cand]) o_grant = w_cand;
    end
  end

  assign o_valid = |i_req;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated round-robin phase scheduler with min/max green, yellow and all-red clearance.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int NUM_APPROACH = DEF_NUM_APPROACH,
  parameter int MIN_GREEN    = DEF_MIN_GREEN,
  parameter int MAX_GREEN    = DEF_MAX_GREEN,
  parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
  parameter int ALLRED_TIME  = DEF_ALLRED_TIME,
  parameter int CWIDTH       = DEF_CWIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  traffic_phase_scheduler_if.slave  bus
);
  localparam int IW = $clog2(NUM_APPROACH);
  localparam logic [CWIDTH-1:0] AR_TC   = CWIDTH'(ALLRED_TIME - 1);
  localparam logic [CWIDTH-1:0] MING_TC = CWIDTH'(MIN_GREEN - 1);
  localparam logic [CWIDTH-1:0] MAXG_TC = CWIDTH'(MAX_GREEN - 1);
  localparam logic [CWIDTH-1:0] Y_TC    = CWIDTH'(YELLOW_TIME - 1);

  phase_e                  r_state, w_state_nxt;
  logic [CWIDTH-1:0]       r_cnt, w_cnt_sat;
  logic [IW-1:0]           r_active_idx, w_active_nxt;
  logic [IW-1:0]           r_last_idx, w_last_nxt;
  logic [IW-1:0]           w_grant;
  logic                    w_valid;
  logic                    w_phase_done;
  logic [NUM_APPROACH-1:0] w_other;

  traffic_rr_picker #(.N(NUM_APPROACH)) u_picker (
    .i_req      (bus.req),
    .i_last_idx (r_last_idx),
    .o_grant    (w_grant),
    .o_valid    (w_valid)
  );

  always_comb begin
    w_other               = bus.req;
    w_other[r_active_idx] = 1'b0;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active_idx;
    w_last_nxt   = r_last_idx;
    w_phase_done = 1'b0;
    w_cnt_sat    = '0;
    case (r_state)
      ST_ALL_RED: begin
        w_cnt_sat = AR_TC;
        if (bus.tick && r_cnt >= AR_TC && w_valid) begin
          w_state_nxt  = ST_GREEN;
          w_active_nxt = w_grant;
          w_last_nxt   = w_grant;
        end
      end
      ST_GREEN: begin
        w_cnt_sat = MAXG_TC;
        // Only yield when someone else is waiting: gap-out or max-out.
        if (bus.tick && (|w_other) &&
            ((r_cnt >= MING_TC && !bus.req[r_active_idx]) || r_cnt >= MAXG_TC))
          w_state_nxt = ST_YELLOW;
      end
      ST_YELLOW: begin
        w_cnt_sat = Y_TC;
        if (bus.tick && r_cnt >= Y_TC) begin
          w_state_nxt  = ST_ALL_RED;
          w_phase_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_ALL_RED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ALL_RED;
      r_cnt        <= '0;
      r_active_idx <= '0;
      r_last_idx   <= IW'(NUM_APPROACH - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_active_idx <= w_active_nxt;
      r_last_idx   <= w_last_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (bus.tick && r_cnt < w_cnt_sat)
        r_cnt <= r_cnt + CWIDTH'(1);
    end
  end

  always_comb begin
    bus.green      = '0;
    bus.yellow     = '0;
    bus.red        = '1;
    bus.active_idx = r_active_idx;
    bus.phase_done = w_phase_done;
    case (r_state)
      ST_GREEN: begin
        bus.green[r_active_idx] = LAMP_ON;
        bus.red[r_active_idx]   = LAMP_OFF;
      end
      ST_YELLOW: begin
        bus.yellow[r_active_idx] = LAMP_ON;
        bus.red[r_active_idx]    = LAMP_OFF;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector table, directed corner sequences, random vs model.
module tb_traffic_phase_scheduler;
  localparam int N    = 4;
  localparam int MING = 4;
  localparam int MAXG = 8;
  localparam int YT   = 2;
  localparam int ART  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  traffic_phase_scheduler_if #(.N(N)) bus ();

  traffic_phase_scheduler #(
    .NUM_APPROACH(N), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
    .YELLOW_TIME(YT), .ALLRED_TIME(ART), .CWIDTH(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase kind, ticks served in the phase, holder, last grant.
  int m_ph;      // 0 all-red, 1 green, 2 yellow
  int m_el;
  int m_hold;
  int m_last;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_el <= 0; m_hold <= 0; m_last <= N - 1;
    end else if (bus.tick) begin
      int pick;
      logic own, others;
      own    = bus.req[m_hold];
      others = (bus.req & ~(4'(1) << m_hold)) != 0;
      pick   = rr_pick(bus.req, m_last);
      case (m_ph)
        0: if (m_el + 1 >= ART && pick >= 0) begin
             m_ph <= 1; m_el <= 0; m_hold <= pick; m_last <= pick;
           end else m_el <= (m_el < 1000) ? m_el + 1 : m_el;
        1: if (others && ((m_el + 1 >= MING && !own) || m_el + 1 >= MAXG)) begin
             m_ph <= 2; m_el <= 0;
           end else m_el <= (m_el < 1000) ? m_el + 1 : m_el;
        default: if (m_el + 1 >= YT) begin
             m_ph <= 0; m_el <= 0;
           end else m_el <= m_el + 1;
      endcase
    end
  end

  function automatic logic [31:0] pack(input logic [3:0] g, input logic [3:0] y,
                                       input logic [3:0] r, input logic [1:0] idx,
                                       input logic pd);
    return {17'b0, g, y, r, idx, pd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_model();
    logic [3:0] eg, ey;
    logic pd;
    eg = (m_ph == 1) ? 4'(1 << m_hold) : 4'b0;
    ey = (m_ph == 2) ? 4'(1 << m_hold) : 4'b0;
    pd = (m_ph == 2) && bus.tick && (m_el + 1 >= YT);
    chk("model", pack(bus.green, bus.yellow, bus.red, bus.active_idx, bus.phase_done),
        pack(eg, ey, ~(eg | ey), 2'(m_hold), pd));
  endtask

  function automatic logic [31:0] dut_out();
    return pack(bus.green, bus.yellow, bus.red, bus.active_idx, bus.phase_done);
  endfunction

  task automatic step(input logic [3:0] r, input logic t);
    @(negedge clk);
    bus.req  = r;
    bus.tick = t;
    #1;
    cmp_model();
  endtask

  task automatic do_reset(input logic [3:0] r, input logic t);
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = r;
    bus.tick = t;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_state", dut_out(), pack(4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0));
  endtask

  typedef struct {
    logic [3:0] req;
    logic       tick;
    logic [3:0] g, y, r;
    logic [1:0] idx;
    logic       pd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int grants[$];
    int glen, ylen;
    logic seen_y;
    logic [3:0] rq;
    logic [3:0] prev_g;

    bus.req  = '0;
    bus.tick = 1'b1;

    // Max-out of approach 0 under req=0011, then hand-over to approach 1.
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0};
    tbl[8]  = '{4'b0011, 1'b1, 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b0};
    tbl[9]  = '{4'b0011, 1'b1, 4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b1};
    tbl[10] = '{4'b0011, 1'b1, 4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b0};
    tbl[11] = '{4'b0011, 1'b1, 4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b0};

    do_reset(4'b0011, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].req, tbl[i].tick);
      chk($sformatf("table_row%0d", i), dut_out(),
          pack(tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].idx, tbl[i].pd));
    end

    // Gap-out after min green, skipping a non-requesting approach.
    do_reset(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    chk("first_green", dut_out(), pack(4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0));
    step(4'b0001, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(4'b0100, 1'b1);
      chk("gap_min_hold", {28'b0, bus.green}, 32'h1);
    end
    step(4'b0100, 1'b1);
    chk("gap_yellow", {28'b0, bus.yellow}, 32'h1);
    step(4'b0100, 1'b1);
    chk("gap_yellow_pd", {31'b0, bus.phase_done}, 32'h1);
    step(4'b0100, 1'b1);
    chk("gap_allred", {28'b0, bus.red}, 32'hF);
    step(4'b0100, 1'b1);
    chk("gap_grant2", dut_out(), pack(4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b0));

    // Lone requester rests in green.
    do_reset(4'b0001, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(4'b0001, 1'b1);
      chk("rest_green", {bus.green, bus.yellow, 3'b0, bus.phase_done}, {4'b0001, 4'b0000, 4'b0000});
    end

    // Sparse timebase: durations scale 4x, grants 0 -> 3 -> 0.
    do_reset(4'b1001, 1'b1);
    glen = 0; ylen = 0; seen_y = 1'b0; prev_g = '0;
    for (int c = 1; c <= 100; c++) begin
      step(4'b1001, (c % 4) == 0);
      if (bus.green != 0 && prev_g == 0) grants.push_back(int'(bus.active_idx));
      if (grants.size() == 1 && bus.green == 4'b0001) glen++;
      if (grants.size() == 1 && bus.yellow != 0) begin ylen++; seen_y = 1'b1; end
      prev_g = bus.green;
    end
    chk("slow_green_len", glen, 32);
    chk("slow_yellow_len", ylen, 8);
    chk("slow_ngrants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("slow_grant0", grants[0], 0);
      chk("slow_grant1", grants[1], 3);
      chk("slow_grant2", grants[2], 0);
    end

    // Asynchronous reset in mid-yellow, then clearance and grant from index 0.
    do_reset(4'b0011, 1'b1);
    for (int i = 0; i < 9; i++) step(4'b0011, 1'b1);
    chk("pre_rst_yellow", {28'b0, bus.yellow}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {20'b0, bus.red, bus.yellow, bus.green}, {20'b0, 4'b1111, 4'b0000, 4'b0000});
    do_reset(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    chk("post_rst_grant0", dut_out(), pack(4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0));

    // Random sensors and timebase against the reference model.
    do_reset(4'($urandom_range(0, 15)), 1'b1);
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
      if (i == 1500) begin
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 cmp_model();
        do_reset(rq, 1'b1);
      end
      step(rq, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
